// File: rtl/audio_vga_pkg.sv
// Shared types and constants for the audio-to-VGA trace path.
// pcm_to_row maps a signed PCM sample onto a saturated VGA row (0 = top).
package audio_vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int Y_MID    = 239;

   typedef logic signed [15:0] pcm_t;
   typedef logic [8:0]         row_t;

   typedef enum logic [1:0] {ARM, FILL, HOLD} wcb_state_t;

   function automatic row_t pcm_to_row(input pcm_t s);
      logic signed [8:0]  s7;
      logic signed [10:0] y;
      s7 = s[15:7];
      y  = 11'(Y_MID) - {{2{s7[8]}}, s7};
      if (y < 11'sd0) begin
         return '0;
      end else if (y > 11'(V_ACTIVE - 1)) begin
         return row_t'(V_ACTIVE - 1);
      end else begin
         return y[8:0];
      end
   endfunction

endpackage

// File: rtl/wcb_bank_ram.sv
// One trace bank: simple dual-port RAM with one write port and a registered read port.
// Contents are never reset, so the array maps onto block RAM.
module wcb_bank_ram
   import audio_vga_pkg::*;
#(
   parameter int DEPTH = H_ACTIVE,
   parameter int AW    = 10
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  row_t          i_wdata,
   input  logic [AW-1:0] i_raddr,
   output row_t          o_rdata
);

   row_t r_mem [DEPTH];
   row_t r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/wave_capture_buffer.sv
// Decimates codec samples, captures one triggered record into the hidden bank, and
// swaps it onto the display bank at vertical blanking while holding the codec.
module wave_capture_buffer
   import audio_vga_pkg::*;
#(
   parameter int N_SAMPLES    = H_ACTIVE,
   parameter int DECIM        = 4,
   parameter int TRIG_LEVEL   = 0,
   parameter int TRIG_TIMEOUT = 2048
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_valid_data,
   input  logic [15:0] i_data_in,
   input  logic       i_frame_start,
   input  logic [9:0] i_rd_x,
   output logic [8:0] o_rd_y,
   output logic       o_listening,
   output logic       o_capture_done
);

   localparam int AW = $clog2(N_SAMPLES);
   localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int TW = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;

   localparam logic [AW-1:0] LAST_ADDR  = AW'(N_SAMPLES - 1);
   localparam logic [DW-1:0] DECIM_LAST = DW'(DECIM - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(TRIG_TIMEOUT - 1);
   localparam pcm_t          TRIG       = pcm_t'(TRIG_LEVEL);

   wcb_state_t    r_state, w_state_next;
   logic          r_disp_bank, w_disp_bank_next;
   logic [AW-1:0] r_wr_addr, w_wr_addr_next;
   logic [DW-1:0] r_decim_cnt, w_decim_cnt_next;
   logic [TW-1:0] r_to_cnt, w_to_cnt_next;
   pcm_t          r_prev, w_prev_next;
   logic          r_prev_valid, w_prev_valid_next;
   logic          r_capture_done, w_capture_done_next;

   logic          r_we, w_we_next;
   logic [AW-1:0] r_we_addr, w_we_addr_next;
   row_t          r_we_data, w_we_data_next;
   logic          r_we_bank, w_we_bank_next;

   logic          r_rd_live, r_rd_oob, r_rd_bank;

   pcm_t          w_cur;
   row_t          w_row;
   logic          w_taken, w_trigger, w_rd_in_range;
   logic [AW-1:0] w_rd_addr;
   row_t          w_bank_q [2];

   assign w_cur     = pcm_t'(i_data_in);
   assign w_row     = pcm_to_row(w_cur);
   assign w_taken   = i_valid_data && (r_decim_cnt == '0) && (r_state != HOLD);
   assign w_trigger = (r_prev_valid && (r_prev < TRIG) && (w_cur >= TRIG)) ||
                      (r_to_cnt == TO_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state        <= ARM;
         r_disp_bank    <= 1'b0;
         r_wr_addr      <= '0;
         r_decim_cnt    <= '0;
         r_to_cnt       <= '0;
         r_prev         <= '0;
         r_prev_valid   <= 1'b0;
         r_capture_done <= 1'b0;
         r_we           <= 1'b0;
         r_we_addr      <= '0;
         r_we_data      <= '0;
         r_we_bank      <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_disp_bank    <= w_disp_bank_next;
         r_wr_addr      <= w_wr_addr_next;
         r_decim_cnt    <= w_decim_cnt_next;
         r_to_cnt       <= w_to_cnt_next;
         r_prev         <= w_prev_next;
         r_prev_valid   <= w_prev_valid_next;
         r_capture_done <= w_capture_done_next;
         r_we           <= w_we_next;
         r_we_addr      <= w_we_addr_next;
         r_we_data      <= w_we_data_next;
         r_we_bank      <= w_we_bank_next;
      end
   end

   always_comb begin
      w_state_next        = r_state;
      w_disp_bank_next    = r_disp_bank;
      w_wr_addr_next      = r_wr_addr;
      w_decim_cnt_next    = r_decim_cnt;
      w_to_cnt_next       = r_to_cnt;
      w_prev_next         = r_prev;
      w_prev_valid_next   = r_prev_valid;
      w_capture_done_next = 1'b0;
      w_we_next           = 1'b0;
      w_we_addr_next      = r_we_addr;
      w_we_data_next      = r_we_data;
      w_we_bank_next      = ~r_disp_bank;

      if (i_valid_data && (r_state != HOLD)) begin
         w_decim_cnt_next = (r_decim_cnt == DECIM_LAST) ? '0 : r_decim_cnt + 1'b1;
      end

      case (r_state)
         ARM: begin
            if (w_taken) begin
               if (w_trigger) begin
                  w_we_next      = 1'b1;
                  w_we_addr_next = '0;
                  w_we_data_next = w_row;
                  w_wr_addr_next = AW'(1);
                  w_state_next   = FILL;
               end else begin
                  w_prev_next       = w_cur;
                  w_prev_valid_next = 1'b1;
                  w_to_cnt_next     = r_to_cnt + 1'b1;
               end
            end
         end
         FILL: begin
            if (w_taken) begin
               w_we_next      = 1'b1;
               w_we_addr_next = r_wr_addr;
               w_we_data_next = w_row;
               if (r_wr_addr == LAST_ADDR) begin
                  w_state_next = HOLD;
               end else begin
                  w_wr_addr_next = r_wr_addr + 1'b1;
               end
            end
         end
         HOLD: begin
            // A sample arriving with the swap is intentionally dropped.
            if (i_frame_start) begin
               w_disp_bank_next    = ~r_disp_bank;
               w_capture_done_next = 1'b1;
               w_wr_addr_next      = '0;
               w_prev_valid_next   = 1'b0;
               w_to_cnt_next       = '0;
               w_decim_cnt_next    = '0;
               w_state_next        = ARM;
            end
         end
         default: begin
            w_state_next = ARM;
         end
      endcase
   end

   assign w_rd_in_range = ({22'd0, i_rd_x} < 32'(N_SAMPLES));
   assign w_rd_addr     = w_rd_in_range ? AW'(i_rd_x) : '0;

   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      wcb_bank_ram #(
         .DEPTH (N_SAMPLES),
         .AW    (AW)
      ) u_ram (
         .i_clk   (i_clk),
         .i_we    (r_we && (r_we_bank == 1'(gi))),
         .i_waddr (r_we_addr),
         .i_wdata (r_we_data),
         .i_raddr (w_rd_addr),
         .o_rdata (w_bank_q[gi])
      );
   end

   // Bank select and range flag are pipelined alongside the RAM read.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_rd_live <= 1'b0;
         r_rd_oob  <= 1'b0;
         r_rd_bank <= 1'b0;
      end else begin
         r_rd_live <= 1'b1;
         r_rd_oob  <= ~w_rd_in_range;
         r_rd_bank <= r_disp_bank;
      end
   end

   assign o_rd_y         = !r_rd_live ? '0 :
                           r_rd_oob   ? row_t'(V_ACTIVE - 1) : w_bank_q[r_rd_bank];
   assign o_listening    = (r_state == HOLD);
   assign o_capture_done = r_capture_done;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Directed checks of wave_capture_buffer with DECIM=4: triggering, timeout, scaling,
// ignored frame pulses, swap-cycle reads and mid-record reset.
module tb_wave_capture_buffer;

   localparam int N   = 640;
   localparam int DEC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        frame = 1'b0;
   logic [15:0] din = '0;
   logic [9:0]  rd_x = '0;
   logic [8:0]  rd_y;
   logic        listening;
   logic        capture_done;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_rec [N];

   typedef struct {
      logic [15:0] data;
      int          exp_y;
   } vec_t;
   vec_t vecs [12];

   always #5 clk = ~clk;

   wave_capture_buffer #(
      .N_SAMPLES    (N),
      .DECIM        (DEC),
      .TRIG_LEVEL   (0),
      .TRIG_TIMEOUT (2048)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst_n),
      .i_valid_data   (valid),
      .i_data_in      (din),
      .i_frame_start  (frame),
      .i_rd_x         (rd_x),
      .o_rd_y         (rd_y),
      .o_listening    (listening),
      .o_capture_done (capture_done)
   );

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Floor division on a non-negative offset, independent of shift semantics.
   function automatic int ref_row(input int v);
      int y;
      y = 239 - ((v + 32768) / 128 - 256);
      if (y < 0) y = 0;
      if (y > 479) y = 479;
      return y;
   endfunction

   task automatic pulse(input logic [15:0] d);
      valid = 1'b1;
      din   = d;
      tick();
      valid = 1'b0;
   endtask

   // One kept sample followed by DEC-1 sign-flipped decoys that must be discarded.
   task automatic feed(input int v);
      logic [15:0] d;
      d = 16'(v);
      pulse(d);
      for (int k = 1; k < DEC; k++) pulse(d ^ 16'h8000);
   endtask

   task automatic swap(input string name);
      frame = 1'b1;
      tick();
      frame = 1'b0;
      check({name, " capture_done"}, int'(capture_done), 1);
      check({name, " listening off"}, int'(listening), 0);
      tick();
      check({name, " capture_done pulse"}, int'(capture_done), 0);
   endtask

   task automatic readback(input string name);
      for (int c = 0; c < N; c++) begin
         rd_x = 10'(c);
         tick();
         check($sformatf("%s col %0d", name, c), int'(rd_y), exp_rec[c]);
      end
   endtask

   initial begin
      int cnt;
      logic seen_cd;

      vecs[0]  = '{16'h7FFF, 0};
      vecs[1]  = '{16'h8000, 479};
      vecs[2]  = '{16'h0000, 239};
      vecs[3]  = '{16'h0F80, 208};
      vecs[4]  = '{16'h0100, 237};
      vecs[5]  = '{16'hFF80, 240};
      vecs[6]  = '{16'h7780, 0};
      vecs[7]  = '{16'h7700, 1};
      vecs[8]  = '{16'h8800, 479};
      vecs[9]  = '{16'h8880, 478};
      vecs[10] = '{16'hF800, 255};
      vecs[11] = '{16'h0080, 238};

      // Reset state
      repeat (3) tick();
      check("reset rd_y", int'(rd_y), 0);
      check("reset listening", int'(listening), 0);
      check("reset capture_done", int'(capture_done), 0);
      rst_n = 1'b1;
      tick();

      // Ramp crossing zero upward at kept sample 37
      for (int k = 0; k < 37; k++) feed((k - 37) * 32);
      for (int c = 0; c < N - 1; c++) begin
         feed(c * 32);
         exp_rec[c] = ref_row(c * 32);
      end
      check("ramp listening before last write", int'(listening), 0);
      exp_rec[N-1] = ref_row((N - 1) * 32);
      pulse(16'((N - 1) * 32));
      check("ramp listening after last write", int'(listening), 1);
      for (int k = 1; k < DEC; k++) pulse(16'h1234);
      check("ramp hold listening", int'(listening), 1);
      check("ramp no early capture_done", int'(capture_done), 0);
      swap("ramp swap");
      readback("ramp rec");

      // Constant input: only the timeout can trigger; frame pulse in ARM ignored
      rd_x    = '0;
      cnt     = 0;
      seen_cd = 1'b0;
      valid   = 1'b1;
      din     = 16'h0100;
      while (!listening && cnt < 12000) begin
         frame = (cnt == 1000);
         tick();
         cnt++;
         if (capture_done) seen_cd = 1'b1;
      end
      valid = 1'b0;
      frame = 1'b0;
      check("timeout pulses until listening", cnt, 10745);
      check("timeout no capture_done in ARM/FILL", int'(seen_cd), 0);
      check("timeout display keeps old record", int'(rd_y), 239);
      swap("timeout swap");
      for (int c = 0; c < N; c++) exp_rec[c] = 237;
      readback("timeout rec");
      rd_x = 10'd700;
      tick();
      check("rd_x 700 baseline", int'(rd_y), 479);
      rd_x = 10'd1023;
      tick();
      check("rd_x 1023 baseline", int'(rd_y), 479);

      // Scaling table; frame pulses in ARM and mid-FILL must not swap
      rd_x  = 10'd5;
      frame = 1'b1;
      tick();
      frame = 1'b0;
      check("ARM frame no capture_done", int'(capture_done), 0);
      feed(16'hFF00 - 65536);
      for (int i = 0; i < 12; i++) begin
         feed(int'($signed(vecs[i].data)));
         exp_rec[i] = vecs[i].exp_y;
      end
      for (int c = 12; c < N; c++) begin
         if (c == 300) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
            check("FILL frame no capture_done", int'(capture_done), 0);
            tick();
            check("FILL frame display unchanged", int'(rd_y), 237);
            check("FILL listening low", int'(listening), 0);
         end
         feed(c * 100 - 32000);
         exp_rec[c] = ref_row(c * 100 - 32000);
      end
      check("table listening", int'(listening), 1);

      // Swap with a coincident sample; read in the swap cycle sees the old bank
      rd_x  = 10'd3;
      valid = 1'b1;
      din   = 16'hFF00;
      frame = 1'b1;
      tick();
      valid = 1'b0;
      frame = 1'b0;
      check("swap+valid capture_done", int'(capture_done), 1);
      check("swap-cycle read old bank", int'(rd_y), 237);
      tick();
      check("post-swap read new bank", int'(rd_y), 208);
      for (int i = 0; i < 12; i++) begin
         rd_x = 10'(i);
         tick();
         check($sformatf("table vec %0d", i), int'(rd_y), vecs[i].exp_y);
      end
      readback("table rec");

      // Dropped swap sample must not act as prev: first trigger is 0x0280
      feed(16'h0500);
      feed(16'h0600);
      feed(-200);
      feed(16'h0280);
      exp_rec[0] = 234;
      for (int c = 1; c < N; c++) begin
         feed(c * 40 - 12000);
         exp_rec[c] = ref_row(c * 40 - 12000);
      end
      check("post-drop listening", int'(listening), 1);
      swap("post-drop swap");
      readback("post-drop rec");

      // Reset at wr_addr 300, then a clean record
      feed(-300);
      for (int c = 0; c < 300; c++) feed(c * 50);
      rst_n = 1'b0;
      tick();
      check("midfill reset rd_y", int'(rd_y), 0);
      check("midfill reset listening", int'(listening), 0);
      check("midfill reset capture_done", int'(capture_done), 0);
      rst_n = 1'b1;
      tick();
      feed(-500);
      for (int c = 0; c < N; c++) begin
         feed(1000 - c * 30);
         exp_rec[c] = ref_row(1000 - c * 30);
      end
      check("after reset listening", int'(listening), 1);
      swap("after reset swap");
      readback("after reset rec");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
